// File: rtl/lfsr_stream_checker_pkg.sv
// Shared definitions for the LFSR stream checker and its matching generator.
// The feedback function lives here so both ends agree by construction.
package lfsr_stream_checker_pkg;

  typedef enum logic {
    ST_SEED  = 1'b0,
    ST_CHECK = 1'b1
  } state_t;

  localparam int                   DEF_WIDTH  = 4;
  localparam logic [DEF_WIDTH-1:0] DEF_TAPS   = 4'b1100;
  localparam int                   LFSR_MAX_W = 64;

  // Callers zero-extend their register and tap mask to LFSR_MAX_W bits.
  function automatic logic lfsr_feedback(input logic [LFSR_MAX_W-1:0] r,
                                         input logic [LFSR_MAX_W-1:0] taps);
    return ^(r & taps);
  endfunction

endpackage

// File: rtl/lfsr_stream_checker_sat_counter.sv
// Saturating event counter with synchronous clear; a clear coinciding with
// an increment leaves the count at one so that event is not lost.
module sat_counter
  import lfsr_stream_checker_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? CNT_W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/lfsr_stream_checker.sv
// Receive-side LFSR checker: self-seeds from the stream, then regenerates and compares.
// Optional macro LFSR_CHK_SELF_SYNC_EN shifts received bits instead of predictions.
module lfsr_stream_checker
  import lfsr_stream_checker_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] TAPS        = DEF_TAPS,
  parameter int               CNT_W       = 8,
  parameter int               RESYNC_ERRS = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clr_cnt,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_count
);

  localparam int SEED_W = $clog2(WIDTH + 1);
  localparam int CONS_W = $clog2(RESYNC_ERRS + 1);

  state_t            state;
  logic [WIDTH-1:0]  r;
  logic [SEED_W-1:0] seed_cnt;
  logic [CONS_W-1:0] consec;

  logic             exp_bit;
  logic             mismatch;
  logic             shift_in;
  logic             cnt_inc;
  logic [WIDTH-1:0] seed_r;

  assign exp_bit  = lfsr_feedback(LFSR_MAX_W'(r), LFSR_MAX_W'(TAPS));
  assign mismatch = (in_bit != exp_bit);
  assign seed_r   = {r[WIDTH-2:0], in_bit};
  assign cnt_inc  = in_valid && (state == ST_CHECK) && mismatch;

`ifdef LFSR_CHK_SELF_SYNC_EN
  assign shift_in = in_bit;
`else
  assign shift_in = exp_bit;
`endif

  // An all-zero seed would lock the regenerator at zero, so seeding restarts instead.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_SEED;
      r        <= '0;
      seed_cnt <= '0;
      consec   <= '0;
      locked   <= 1'b0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      if (in_valid) begin
        case (state)
          ST_SEED: begin
            r <= seed_r;
            if (seed_cnt == SEED_W'(WIDTH - 1)) begin
              seed_cnt <= '0;
              if (seed_r != '0) begin
                state  <= ST_CHECK;
                locked <= 1'b1;
                consec <= '0;
              end
            end else begin
              seed_cnt <= seed_cnt + SEED_W'(1);
            end
          end
          ST_CHECK: begin
            r <= {r[WIDTH-2:0], shift_in};
            if (mismatch) begin
              err <= 1'b1;
              if (consec == CONS_W'(RESYNC_ERRS - 1)) begin
                state    <= ST_SEED;
                seed_cnt <= '0;
                consec   <= '0;
                locked   <= 1'b0;
              end else begin
                consec <= consec + CONS_W'(1);
              end
            end else begin
              consec <= '0;
            end
          end
          default: state <= ST_SEED;
        endcase
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cnt_inc),
    .clr  (clr_cnt),
    .count(err_count)
  );

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker (WIDTH=4, TAPS=4'b1100, seed 4'b1001).
// Honours LFSR_CHK_SELF_SYNC_EN when computing expected error pulses.
module tb_lfsr_stream_checker;

  localparam int CNT_W = 8;

`ifdef LFSR_CHK_SELF_SYNC_EN
  localparam int SINGLE_ERR_PULSES = 3;
`else
  localparam int SINGLE_ERR_PULSES = 1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_bit;
  logic             clr_cnt;
  logic             locked;
  logic             err;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;
  int pos;
  int pulses;

  // Generator output for seed 1001: bit i of pat is stream bit i.
  logic [14:0] pat = 15'b000111101011001;

  typedef struct {
    logic v;
    logic b;
    logic c;
    logic l;
    logic e;
    int   cnt;
  } vec_t;

  vec_t tbl[21];

  always #5 clk = ~clk;

  lfsr_stream_checker #(
    .WIDTH      (4),
    .TAPS       (4'b1100),
    .CNT_W      (CNT_W),
    .RESYNC_ERRS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .clr_cnt  (clr_cnt),
    .locked   (locked),
    .err      (err),
    .err_count(err_count)
  );

  function automatic logic sbit(input int p);
    return pat[p % 15];
  endfunction

  function automatic vec_t mkv(input logic v, input logic b, input logic c,
                               input logic l, input logic e, input int cnt);
    vec_t t;
    t.v = v; t.b = b; t.c = c; t.l = l; t.e = e; t.cnt = cnt;
    return t;
  endfunction

  task applyStimulus(input logic v, input logic b, input logic c);
    @(negedge clk);
    in_valid = v;
    in_bit   = b;
    clr_cnt  = c;
    @(posedge clk);
    #1;
  endtask

  task sendStream(input logic invert);
    applyStimulus(1'b1, sbit(pos) ^ invert, 1'b0);
    pos++;
  endtask

  task checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task checkAll(input string name, input logic l, input logic e, input int cnt);
    checkOutput({name, " locked"}, {31'd0, locked}, {31'd0, l});
    checkOutput({name, " err"}, {31'd0, err}, {31'd0, e});
    checkOutput({name, " err_count"}, 32'(err_count), cnt);
  endtask

  task doReset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task seedFromStream(input string name);
    for (int i = 0; i < 4; i++) begin
      sendStream(1'b0);
      checkOutput($sformatf("%s seed%0d locked", name, i), {31'd0, locked}, (i == 3) ? 1 : 0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; clr_cnt = 1'b0;

    // Reset state
    doReset;
    checkAll("reset", 1'b0, 1'b0, 0);

    // Table: seeding with gaps, clean run, single mismatch, clear
    tbl[0]  = mkv(1, 1, 0, 0, 0, 0);
    tbl[1]  = mkv(1, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(0, 1, 0, 0, 0, 0);
    tbl[3]  = mkv(1, 0, 0, 0, 0, 0);
    tbl[4]  = mkv(1, 1, 0, 1, 0, 0);
    tbl[5]  = mkv(0, 0, 0, 1, 0, 0);
    tbl[6]  = mkv(1, 1, 0, 1, 0, 0);
    tbl[7]  = mkv(1, 0, 0, 1, 0, 0);
    tbl[8]  = mkv(1, 1, 0, 1, 0, 0);
    tbl[9]  = mkv(0, 0, 0, 1, 0, 0);
    tbl[10] = mkv(1, 0, 0, 1, 0, 0);
    tbl[11] = mkv(1, 1, 0, 1, 0, 0);
    tbl[12] = mkv(1, 1, 0, 1, 0, 0);
    tbl[13] = mkv(1, 1, 0, 1, 0, 0);
    tbl[14] = mkv(1, 1, 0, 1, 0, 0);
    tbl[15] = mkv(1, 0, 0, 1, 0, 0);
    tbl[16] = mkv(1, 0, 0, 1, 0, 0);
    tbl[17] = mkv(1, 0, 0, 1, 0, 0);
    tbl[18] = mkv(1, 0, 0, 1, 1, 1);
    tbl[19] = mkv(0, 0, 0, 1, 0, 1);
    tbl[20] = mkv(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 21; i++) begin
      applyStimulus(tbl[i].v, tbl[i].b, tbl[i].c);
      checkAll($sformatf("vec%0d", i), tbl[i].l, tbl[i].e, tbl[i].cnt);
    end

    // Clean lock followed by 30 stream bits
    doReset;
    pos = 0;
    seedFromStream("clean");
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      sendStream(1'b0);
      pulses += int'(err);
    end
    checkOutput("clean pulses", pulses, 0);
    checkAll("clean end", 1'b1, 1'b0, 0);

    // Single flipped bit at stream position 5
    doReset;
    pos = 0;
    seedFromStream("single");
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      sendStream(pos == 5);
      if (pos == 6) checkOutput("single first pulse", {31'd0, err}, 1);
      pulses += int'(err);
    end
    checkOutput("single pulses", pulses, SINGLE_ERR_PULSES);
    checkAll("single end", 1'b1, 1'b0, SINGLE_ERR_PULSES);

    // Lockup seed: zeros must not lock
    doReset;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("lockup zero%0d locked", i), {31'd0, locked}, 0);
    end
    pos = 0;
    seedFromStream("lockup");

    // Resync after three consecutive mismatches
    doReset;
    pos = 0;
    seedFromStream("resync");
    for (int i = 0; i < 6; i++) sendStream(1'b0);
    for (int i = 0; i < 3; i++) begin
      sendStream(1'b1);
      checkAll($sformatf("resync bad%0d", i), (i < 2), 1'b1, i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      sendStream(1'b0);
      checkAll($sformatf("resync reseed%0d", i), (i == 3), 1'b0, 3);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      sendStream(1'b0);
      pulses += int'(err);
    end
    checkOutput("resync clean pulses", pulses, 0);
    checkAll("resync end", 1'b1, 1'b0, 3);

    // Gaps between seed bits, then clear coinciding with a mismatch
    doReset;
    pos = 0;
    for (int i = 0; i < 4; i++) begin
      sendStream(1'b0);
      checkOutput($sformatf("gap seed%0d locked", i), {31'd0, locked}, (i == 3) ? 1 : 0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput($sformatf("gap idle%0d locked", i), {31'd0, locked}, (i == 3) ? 1 : 0);
    end
    sendStream(1'b0);
    checkAll("gap pos4", 1'b1, 1'b0, 0);
    sendStream(1'b1);
    checkAll("gap pos5 bad", 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkAll("gap idle after err", 1'b1, 1'b0, 1);
    sendStream(1'b0);
    checkAll("gap pos6", 1'b1, 1'b0, 1);
    applyStimulus(1'b1, sbit(pos) ^ 1'b1, 1'b1);
    pos++;
    checkAll("clr with mismatch", 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clr alone count", 32'(err_count), 0);

    // Reset in the middle of CHECK, then re-seed from the current position
    doReset;
    pos = 0;
    seedFromStream("midrst");
    for (int i = 0; i < 10; i++) sendStream(pos == 6);
    checkOutput("midrst count before", 32'(err_count), SINGLE_ERR_PULSES);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkAll("midrst after reset", 1'b0, 1'b0, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sendStream(1'b0);
      checkOutput($sformatf("midrst reseed%0d locked", i), {31'd0, locked}, (i == 3) ? 1 : 0);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      sendStream(1'b0);
      pulses += int'(err);
    end
    checkOutput("midrst clean pulses", pulses, 0);
    checkAll("midrst end", 1'b1, 1'b0, 0);

    // Constant ones: every checked bit mismatches, resyncing every 7 samples
    doReset;
    pulses = 0;
    for (int i = 0; i < 700; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      pulses += int'(err);
    end
    checkOutput("sat pulses", pulses, 300);
    checkOutput("sat count", 32'(err_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
